// File: rtl/ysyx_24080014_lsu_req_if.sv
// EXU request, data-memory request/response and WBU result signals of the load/store initiator.
// slave is the LSU's own view; master is the view of whatever drives it (EXU, memory, WBU).
interface ysyx_24080014_lsu_req_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic        in_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;

  logic        mem_ren;
  logic        mem_wen;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic [1:0]  out_err;

  modport slave (
    input  in_valid, in_load, in_store, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_ren, mem_wen, mem_valid, mem_addr, mem_wmask, mem_wdata,
    input  mem_ready, mem_rdata,
    output out_valid, out_rdata, out_rd, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_load, in_store, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_ren, mem_wen, mem_valid, mem_addr, mem_wmask, mem_wdata,
    output mem_ready, mem_rdata,
    input  out_valid, out_rdata, out_rd, out_err,
    output out_ready
  );
endinterface

// File: rtl/ysyx_24080014_lsu_req.sv
// Load/store initiator: one op per EXU handshake, 1 cycle accept->request, 1 cycle mem_ready->out_valid.
// Holds in_ready low outside IDLE; the result waits in RESP until out_ready (at most one op per 3 cycles).
module ysyx_24080014_lsu_req #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_24080014_lsu_req_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0]       ERR_OK  = 2'b00;
  localparam logic [1:0]       ERR_MIS = 2'b01;
  localparam logic [1:0]       ERR_TO  = 2'b10;
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic               is_load_q, is_load_d;
  logic               is_store_q, is_store_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [4:0]         rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         err_q, err_d;

  logic        accept;
  logic        misalign;
  logic        noop;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;
  logic [3:0]  wmask;

  assign accept = (state_q == S_IDLE) && bus.in_valid;
  assign noop   = !bus.in_load && !bus.in_store;

  always_comb begin
    misalign = 1'b0;
    case (bus.in_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = bus.in_addr[0];
      default: misalign = (bus.in_addr[1:0] != 2'b00);
    endcase
  end

  // Memory word is lane-aligned; shift the addressed byte down to bit 0 before extending.
  always_comb begin
    ld_shift = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   ld_ext = {{24{!uns_q && ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_ext = {{16{!uns_q && ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   wmask = 4'b0001 << addr_q[1:0];
      2'b01:   wmask = 4'b0011 << addr_q[1:0];
      default: wmask = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misalign || noop) state_d = S_RESP;
          else                  state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_ready || (cnt_q == TO_CNT)) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    is_load_d  = is_load_q;
    is_store_d = is_store_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_load_d  = bus.in_load;
          is_store_d = bus.in_store && !bus.in_load;
          size_d     = bus.in_size;
          uns_d      = bus.in_unsigned;
          addr_d     = bus.in_addr;
          wdata_d    = bus.in_wdata;
          rd_d       = bus.in_rd;
          cnt_d      = '0;
          rdata_d    = '0;
          err_d      = misalign ? ERR_MIS : ERR_OK;
        end
      end
      S_REQ: begin
        // A completion in the timeout cycle still counts as success.
        if (bus.mem_ready) begin
          if (is_load_q) rdata_d = ld_ext;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TO_CNT) err_d = ERR_TO;
        end
      end
      S_RESP: begin
        if (bus.out_ready) begin
          rdata_d = '0;
          err_d   = ERR_OK;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= ERR_OK;
    end else begin
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.mem_valid = (state_q != S_REQ);
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wmask = '0;
    bus.mem_wdata = '0;
    bus.out_valid = (state_q == S_RESP);
    bus.out_rdata = rdata_q;
    bus.out_err   = err_q;
    bus.out_rd    = rd_q;
    if (state_q == S_REQ) begin
      bus.mem_ren   = is_load_q;
      bus.mem_wen   = is_store_q;
      bus.mem_addr  = {addr_q[31:2], 2'b00};
      bus.mem_wmask = is_store_q ? {4'b0000, wmask} : 8'h00;
      bus.mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_lsu_req.sv
// Randomized and directed bench for the load/store initiator with a byte-level reference model.
module tb_ysyx_24080014_lsu_req;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  ysyx_24080014_lsu_req_if bus ();

  ysyx_24080014_lsu_req #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected behaviour from byte-lane arithmetic on the access description.
  function automatic void model(input logic ld, input logic st, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output logic mis, output logic noop, output logic [3:0] mask,
                                output logic [31:0] wd, output logic [31:0] lv);
    int nb;
    int off;
    logic [7:0] b [4];
    logic [7:0] fill;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off  = int'(addr[1:0]);
    mis  = (off % nb) != 0;
    noop = !ld && !st;
    mask = (st && !ld) ? 4'(((1 << nb) - 1) << off) : 4'h0;
    wd   = wdata << (8 * off);
    for (int i = 0; i < 4; i++) b[i] = 8'h00;
    for (int i = 0; i < nb; i++) if (off + i < 4) b[i] = rdata[8*(off+i) +: 8];
    fill = (!uns && b[nb-1][7]) ? 8'hFF : 8'h00;
    for (int i = nb; i < 4; i++) b[i] = fill;
    lv = {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_load = 0; bus.in_store = 0; bus.in_size = 0;
    bus.in_unsigned = 0; bus.in_addr = 0; bus.in_wdata = 0; bus.in_rd = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0; bus.out_ready = 0;
  endtask

  // Issue one op, play memory with a given ready delay, hold the result for 'hold' cycles.
  task automatic run_op(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int rdly, input logic [31:0] rdata,
                        input int hold);
    logic mis, noop, do_mem;
    logic [3:0] mask;
    logic [31:0] wd, lv, exp_rdata;
    logic [1:0] exp_err;
    int nreq;
    model(ld, st, sz, uns, addr, wdata, rdata, mis, noop, mask, wd, lv);
    do_mem = !mis && !noop;
    bus.in_valid = 1; bus.in_load = ld; bus.in_store = st; bus.in_size = sz;
    bus.in_unsigned = uns; bus.in_addr = addr; bus.in_wdata = wdata; bus.in_rd = rd;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL %s idle_in_ready: got %b want 1", nm, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 0; bus.in_addr = $urandom; bus.in_wdata = $urandom; bus.in_rd = 5'($urandom);
    exp_err = mis ? 2'b01 : 2'b00;
    exp_rdata = 32'h0;
    if (do_mem) begin
      nreq = (rdly <= TO) ? rdly + 1 : TO + 1;
      exp_err = (rdly <= TO) ? 2'b00 : 2'b10;
      exp_rdata = (ld && rdly <= TO) ? lv : 32'h0;
      for (int k = 0; k < nreq; k++) begin
        vecs++; if (bus.mem_ren !== ld) begin errs++; $display("FAIL %s req_ren k=%0d: got %b want %b", nm, k, bus.mem_ren, ld); end
        vecs++; if (bus.mem_wen !== (st && !ld)) begin errs++; $display("FAIL %s req_wen k=%0d: got %b want %b", nm, k, bus.mem_wen, st && !ld); end
        vecs++; if (bus.mem_addr !== {addr[31:2], 2'b00}) begin errs++; $display("FAIL %s req_addr: got %h want %h", nm, bus.mem_addr, {addr[31:2], 2'b00}); end
        vecs++; if (bus.mem_wmask !== {4'h0, mask}) begin errs++; $display("FAIL %s req_wmask: got %h want %h", nm, bus.mem_wmask, {4'h0, mask}); end
        if (st && !ld) begin
          vecs++; if (bus.mem_wdata !== wd) begin errs++; $display("FAIL %s req_wdata: got %h want %h", nm, bus.mem_wdata, wd); end
        end
        vecs++; if ({bus.mem_valid, bus.out_valid, bus.in_ready} !== 3'b000) begin errs++; $display("FAIL %s req_flags: got %b want 000", nm, {bus.mem_valid, bus.out_valid, bus.in_ready}); end
        bus.mem_ready = (k == rdly);
        bus.mem_rdata = (k == rdly) ? rdata : $urandom;
        @(negedge clk);
      end
      bus.mem_ready = 0; bus.mem_rdata = $urandom;
    end
    for (int h = 0; h <= hold; h++) begin
      vecs++; if ({bus.out_valid, bus.in_ready, bus.mem_ren, bus.mem_wen, bus.mem_valid} !== 5'b10001) begin errs++; $display("FAIL %s resp_flags h=%0d: got %b want 10001", nm, h, {bus.out_valid, bus.in_ready, bus.mem_ren, bus.mem_wen, bus.mem_valid}); end
      vecs++; if (bus.out_err !== exp_err) begin errs++; $display("FAIL %s resp_err: got %b want %b", nm, bus.out_err, exp_err); end
      vecs++; if (bus.out_rdata !== exp_rdata) begin errs++; $display("FAIL %s resp_rdata: got %h want %h", nm, bus.out_rdata, exp_rdata); end
      vecs++; if (bus.out_rd !== rd) begin errs++; $display("FAIL %s resp_rd: got %0d want %0d", nm, bus.out_rd, rd); end
      bus.out_ready = (h == hold);
      @(negedge clk);
    end
    bus.out_ready = 0;
    vecs++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errs++; $display("FAIL %s done_flags: got %b want 01", nm, {bus.out_valid, bus.in_ready}); end
    vecs++; if ({bus.out_rdata, bus.out_err} !== 34'h0) begin errs++; $display("FAIL %s done_clear: got %h/%b want 0/00", nm, bus.out_rdata, bus.out_err); end
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    #12;
    vecs++; if ({bus.in_ready, bus.mem_valid} !== 2'b11) begin errs++; $display("FAIL reset_ready_valid: got %b want 11", {bus.in_ready, bus.mem_valid}); end
    vecs++; if ({bus.mem_ren, bus.mem_wen, bus.out_valid} !== 3'b000) begin errs++; $display("FAIL reset_strobes: got %b want 000", {bus.mem_ren, bus.mem_wen, bus.out_valid}); end
    vecs++; if ({bus.mem_addr, bus.mem_wmask, bus.mem_wdata} !== 72'h0) begin errs++; $display("FAIL reset_mem_bus: got %h want 0", {bus.mem_addr, bus.mem_wmask, bus.mem_wdata}); end
    vecs++; if ({bus.out_rdata, bus.out_rd, bus.out_err} !== 39'h0) begin errs++; $display("FAIL reset_out_bus: got %h want 0", {bus.out_rdata, bus.out_rd, bus.out_err}); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    run_op("word_store", 0, 1, 2'd2, 0, 32'h8000_0004, 32'hDEAD_BEEF, 5'd3, 2, 32'h1234_5678, 0);
  endtask

  task automatic test_byte_load();
    run_op("byte_load_s", 1, 0, 2'd0, 0, 32'h8000_0003, 32'h0, 5'd7, 1, 32'h80FF_1234, 0);
    run_op("byte_load_u", 1, 0, 2'd0, 1, 32'h8000_0003, 32'h0, 5'd8, 0, 32'h80FF_1234, 0);
    run_op("half_load_s", 1, 0, 2'd1, 0, 32'h8000_0002, 32'h0, 5'd9, 0, 32'h80FF_1234, 0);
  endtask

  task automatic test_half_store_misaligned();
    run_op("half_store", 0, 1, 2'd1, 0, 32'h8000_0002, 32'h0000_ABCD, 5'd4, 0, 32'h0, 0);
    run_op("half_load_mis", 1, 0, 2'd1, 0, 32'h8000_0001, 32'h0, 5'd5, 0, 32'hFFFF_FFFF, 0);
    run_op("word_store_mis", 0, 1, 2'd3, 0, 32'h8000_0006, 32'h1, 5'd6, 0, 32'h0, 0);
    run_op("noop", 0, 0, 2'd2, 0, 32'h8000_0000, 32'h5, 5'd10, 0, 32'h0, 0);
  endtask

  task automatic test_timeout();
    run_op("timeout", 1, 0, 2'd2, 0, 32'h8000_0100, 32'h0, 5'd11, 100, 32'hCAFE_F00D, 0);
    run_op("ready_at_limit", 1, 0, 2'd2, 0, 32'h8000_0104, 32'h0, 5'd12, TO, 32'hCAFE_F00D, 0);
    bus.mem_ready = 1; bus.mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errs++; $display("FAIL idle_ready_ignored: got %b want 01", {bus.out_valid, bus.in_ready}); end
    end
    bus.mem_ready = 0;
  endtask

  task automatic test_backpressure();
    run_op("backpressure", 1, 1, 2'd2, 0, 32'h8000_0200, 32'h0, 5'd13, 1, 32'h7654_3210, 5);
  endtask

  task automatic test_reset_mid_req();
    bus.in_valid = 1; bus.in_load = 1; bus.in_store = 0; bus.in_size = 2'd2;
    bus.in_unsigned = 0; bus.in_addr = 32'h8000_0010; bus.in_rd = 5'd14;
    @(negedge clk);
    bus.in_valid = 0;
    vecs++; if (bus.mem_ren !== 1'b1) begin errs++; $display("FAIL midreq_ren_before: got %b want 1", bus.mem_ren); end
    #2 rst = 0;
    #1;
    vecs++; if ({bus.mem_ren, bus.in_ready, bus.out_valid, bus.mem_valid} !== 4'b0101) begin errs++; $display("FAIL midreq_async: got %b want 0101", {bus.mem_ren, bus.in_ready, bus.out_valid, bus.mem_valid}); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    vecs++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errs++; $display("FAIL midreq_no_completion: got %b want 01", {bus.out_valid, bus.in_ready}); end
    run_op("after_reset_load", 1, 0, 2'd2, 0, 32'h8000_0020, 32'h0, 5'd15, 1, 32'hA5A5_5A5A, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_op("random", 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
             {16'h8000, 16'($urandom)}, $urandom, 5'($urandom),
             int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_store_misaligned();
    test_timeout();
    test_backpressure();
    test_reset_mid_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
